// File: rtl/uart_reg_bridge_pkg.sv
// uart_reg_bridge_pkg
//   Shared constants and state type for the UART register bridge.
//   - CMD_WRITE / CMD_READ : host command bytes
//   - RSP_ACK / RSP_NAK    : response bytes
//   - state_t              : bridge FSM state encoding
package uart_reg_bridge_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    REG_WR,
    REG_RD,
    RD_CAP,
    SEND,
    WAIT_DONE
  } state_t;

endpackage

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge
//   Decodes host command frames from the UART receiver byte stream
//   ('W' addr data / 'R' addr), performs 8-bit register accesses on a
//   local strobe bus and returns a one-byte response (ACK, read data or
//   NAK) through the transmitter start/done handshake.
//
//   Ports:
//     i_clk, i_rst                  clock, async active-high reset
//     i_rx_new, i_rx_err, i_rx_data receiver byte stream / framing error
//     o_tx_start, o_tx_data,
//     i_tx_done                     transmitter handshake
//     o_reg_addr, o_reg_wdata,
//     o_reg_we, o_reg_re,
//     i_reg_rdata                   register bus (rdata sampled one
//                                   cycle after o_reg_re)
//     o_busy                        state is not IDLE
//     o_frame_err                   bad command / rx error / timeout pulse
//
//   Build option: UART_REG_BRIDGE_TIMEOUT_EN enables the inter-byte
//   timeout (p_timeout_cycles); without it a partial frame waits forever.
module uart_reg_bridge
  import uart_reg_bridge_pkg::*;
#(
  parameter int unsigned p_timeout_cycles = 100000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx_new,
  input  logic       i_rx_err,
  input  logic [7:0] i_rx_data,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  input  logic       i_tx_done,
  output logic [7:0] o_reg_addr,
  output logic [7:0] o_reg_wdata,
  output logic       o_reg_we,
  output logic       o_reg_re,
  input  logic [7:0] i_reg_rdata,
  output logic       o_busy,
  output logic       o_frame_err
);

  state_t     state, state_n;
  logic       cmd_write, cmd_write_n;
  logic [7:0] addr_n, wdata_n, tx_data_n;
  logic       we_n, re_n, start_n, err_n;
  logic       timeout;

`ifdef UART_REG_BRIDGE_TIMEOUT_EN
  localparam int unsigned CW = (p_timeout_cycles > 2) ? $clog2(p_timeout_cycles) : 1;
  logic [CW-1:0] to_cnt;
  logic          in_frame;

  assign in_frame = (state == GET_ADDR) || (state == GET_DATA);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      to_cnt <= '0;
    end else if (!in_frame || i_rx_new || i_rx_err) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + CW'(1);
    end
  end

  assign timeout = in_frame && (to_cnt == CW'(p_timeout_cycles - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n     = state;
    cmd_write_n = cmd_write;
    addr_n      = o_reg_addr;
    wdata_n     = o_reg_wdata;
    tx_data_n   = o_tx_data;
    err_n       = 1'b0;

    case (state)
      IDLE: begin
        if (i_rx_err) begin
          err_n     = 1'b1;
          tx_data_n = RSP_NAK;
          state_n   = SEND;
        end else if (i_rx_new) begin
          if (i_rx_data == CMD_WRITE) begin
            cmd_write_n = 1'b1;
            state_n     = GET_ADDR;
          end else if (i_rx_data == CMD_READ) begin
            cmd_write_n = 1'b0;
            state_n     = GET_ADDR;
          end else begin
            err_n     = 1'b1;
            tx_data_n = RSP_NAK;
            state_n   = SEND;
          end
        end
      end
      GET_ADDR: begin
        if (i_rx_err) begin
          err_n     = 1'b1;
          tx_data_n = RSP_NAK;
          state_n   = SEND;
        end else if (i_rx_new) begin
          addr_n  = i_rx_data;
          state_n = cmd_write ? GET_DATA : REG_RD;
        end else if (timeout) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      GET_DATA: begin
        if (i_rx_err) begin
          err_n     = 1'b1;
          tx_data_n = RSP_NAK;
          state_n   = SEND;
        end else if (i_rx_new) begin
          wdata_n = i_rx_data;
          state_n = REG_WR;
        end else if (timeout) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      REG_WR: begin
        tx_data_n = RSP_ACK;
        state_n   = SEND;
      end
      REG_RD:  state_n = RD_CAP;
      RD_CAP: begin
        tx_data_n = i_reg_rdata;
        state_n   = SEND;
      end
      // After an error the frame_err pulse occupies the first SEND cycle,
      // so SEND is held once and the start strobe follows one cycle later.
      SEND:    state_n = o_frame_err ? SEND : WAIT_DONE;
      WAIT_DONE: begin
        if (i_tx_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Strobes are registered: decode them from the upcoming state.
    we_n    = (state_n == REG_WR);
    re_n    = (state_n == REG_RD);
    start_n = (state_n == SEND) && !err_n;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      cmd_write   <= 1'b0;
      o_reg_addr  <= '0;
      o_reg_wdata <= '0;
      o_tx_data   <= '0;
      o_reg_we    <= 1'b0;
      o_reg_re    <= 1'b0;
      o_tx_start  <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_n;
      cmd_write   <= cmd_write_n;
      o_reg_addr  <= addr_n;
      o_reg_wdata <= wdata_n;
      o_tx_data   <= tx_data_n;
      o_reg_we    <= we_n;
      o_reg_re    <= re_n;
      o_tx_start  <= start_n;
      o_frame_err <= err_n;
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_reg_bridge.sv
// tb_uart_reg_bridge
//   Scoreboard bench for uart_reg_bridge. Expected strobes/responses are
//   queued with their expected cycle when stimulus is driven and checked
//   when the DUT produces them. Honours UART_REG_BRIDGE_TIMEOUT_EN.
module tb_uart_reg_bridge;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_rx_new, i_rx_err;
  logic [7:0] i_rx_data;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       i_tx_done;
  logic [7:0] o_reg_addr, o_reg_wdata;
  logic       o_reg_we, o_reg_re;
  logic [7:0] i_reg_rdata;
  logic       o_busy, o_frame_err;

  uart_reg_bridge #(.p_timeout_cycles(50)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rx_new   (i_rx_new),
    .i_rx_err   (i_rx_err),
    .i_rx_data  (i_rx_data),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .i_tx_done  (i_tx_done),
    .o_reg_addr (o_reg_addr),
    .o_reg_wdata(o_reg_wdata),
    .o_reg_we   (o_reg_we),
    .o_reg_re   (o_reg_re),
    .i_reg_rdata(i_reg_rdata),
    .o_busy     (o_busy),
    .o_frame_err(o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  ev_t q_we[$], q_re[$], q_err[$], q_tx[$];

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         tx_wait = 0;
  int         tx_delay = 3;
  logic [7:0] tx_hold = '0;
  logic [7:0] rd_val = '0;
  logic       re_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge i_clk) cyc++;

  // Monitor, register-bus responder and transmitter model.
  always @(negedge i_clk) begin
    ev_t e;
    i_reg_rdata = re_prev ? rd_val : 8'hEE;
    re_prev     = o_reg_re;
    if (i_rst) begin
      tx_wait   = 0;
      i_tx_done = 1'b0;
    end else begin
      if (i_tx_done) begin
        i_tx_done = 1'b0;
        check("busy_fall", o_busy, 0);
      end
      if (tx_wait > 0) begin
        check("tx_hold", o_tx_data, tx_hold);
        tx_wait--;
        if (tx_wait == 0) begin
          i_tx_done = 1'b1;
          check("busy_high", o_busy, 1);
        end
      end
      if (o_reg_we) begin
        if (q_we.size() == 0) check("we_unexpected", 1, 0);
        else begin
          e = q_we.pop_front();
          check("we_cycle", cyc, e.cyc);
          check("we_addr", o_reg_addr, e.a);
          check("we_data", o_reg_wdata, e.d);
        end
      end
      if (o_reg_re) begin
        if (q_re.size() == 0) check("re_unexpected", 1, 0);
        else begin
          e = q_re.pop_front();
          check("re_cycle", cyc, e.cyc);
          check("re_addr", o_reg_addr, e.a);
        end
      end
      if (o_frame_err) begin
        if (q_err.size() == 0) check("err_unexpected", 1, 0);
        else begin
          e = q_err.pop_front();
          check("err_cycle", cyc, e.cyc);
        end
      end
      if (o_tx_start) begin
        if (q_tx.size() == 0) check("tx_unexpected", 1, 0);
        else begin
          e = q_tx.pop_front();
          check("tx_cycle", cyc, e.cyc);
          check("tx_data", o_tx_data, e.d);
        end
        tx_hold = o_tx_data;
        tx_wait = tx_delay;
      end
    end
  end

  // One receiver event in a single cycle; n returns that cycle number.
  task automatic send(input logic [7:0] b, input logic nw, input logic er, output int n);
    @(posedge i_clk);
    #1;
    i_rx_data = b;
    i_rx_new  = nw;
    i_rx_err  = er;
    n = cyc;
    @(posedge i_clk);
    #1;
    i_rx_new = 1'b0;
    i_rx_err = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    int k;
    k = 0;
    while ((o_busy || tx_wait != 0 || i_tx_done || q_tx.size() != 0 ||
            q_we.size() != 0 || q_re.size() != 0 || q_err.size() != 0) && k < max_cycles) begin
      @(posedge i_clk);
      k++;
    end
    #1;
    if (k >= max_cycles) check("idle_timeout", 0, 1);
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, o_tx_start, 0);
    check({tag, "_tx_data"}, o_tx_data, 0);
    check({tag, "_addr"}, o_reg_addr, 0);
    check({tag, "_wdata"}, o_reg_wdata, 0);
    check({tag, "_we"}, o_reg_we, 0);
    check({tag, "_re"}, o_reg_re, 0);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_frame_err"}, o_frame_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    i_rst = 1'b1;
    i_rx_new = 1'b0;
    i_rx_err = 1'b0;
    i_rx_data = '0;
    i_tx_done = 1'b0;
    i_reg_rdata = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check_reset_outputs("rst");
    i_rst = 1'b0;

    // Write 0x57 0x10 0xA5
    send(8'h57, 1, 0, n);
    send(8'h10, 1, 0, n);
    send(8'hA5, 1, 0, n);
    q_we.push_back('{n + 1, 8'h10, 8'hA5});
    q_tx.push_back('{n + 2, 8'h00, 8'h06});
    wait_idle(100);

    // Read 0x52 0x22 -> 0x3C
    rd_val = 8'h3C;
    send(8'h52, 1, 0, n);
    send(8'h22, 1, 0, n);
    q_re.push_back('{n + 1, 8'h22, 8'h00});
    q_tx.push_back('{n + 3, 8'h00, 8'h3C});
    wait_idle(100);

    // Bad command
    send(8'h41, 1, 0, n);
    q_err.push_back('{n + 1, 8'h00, 8'h00});
    q_tx.push_back('{n + 2, 8'h00, 8'h15});
    wait_idle(100);

    // Rx error in GET_DATA, then a good write
    send(8'h57, 1, 0, n);
    send(8'h10, 1, 0, n);
    send(8'h00, 0, 1, n);
    q_err.push_back('{n + 1, 8'h00, 8'h00});
    q_tx.push_back('{n + 2, 8'h00, 8'h15});
    wait_idle(100);
    check("wdata_kept", o_reg_wdata, 8'hA5);
    send(8'h57, 1, 0, n);
    send(8'h33, 1, 0, n);
    send(8'h5A, 1, 0, n);
    q_we.push_back('{n + 1, 8'h33, 8'h5A});
    q_tx.push_back('{n + 2, 8'h00, 8'h06});
    wait_idle(100);

    // Byte and error together: error wins, byte discarded
    send(8'h52, 1, 1, n);
    q_err.push_back('{n + 1, 8'h00, 8'h00});
    q_tx.push_back('{n + 2, 8'h00, 8'h15});
    wait_idle(100);
    rd_val = 8'hC3;
    send(8'h52, 1, 0, n);
    send(8'h7E, 1, 0, n);
    q_re.push_back('{n + 1, 8'h7E, 8'h00});
    q_tx.push_back('{n + 3, 8'h00, 8'hC3});
    wait_idle(100);

    // Inter-byte timeout
    send(8'h52, 1, 0, n);
`ifdef UART_REG_BRIDGE_TIMEOUT_EN
    q_err.push_back('{n + 51, 8'h00, 8'h00});
    repeat (60) @(posedge i_clk);
    #1;
    check("timeout_idle", o_busy, 0);
    wait_idle(100);
`else
    repeat (60) @(posedge i_clk);
    #1;
    check("no_timeout_busy", o_busy, 1);
    rd_val = 8'h99;
    send(8'h05, 1, 0, n);
    q_re.push_back('{n + 1, 8'h05, 8'h00});
    q_tx.push_back('{n + 3, 8'h00, 8'h99});
    wait_idle(100);
`endif

    // Bytes arriving during WAIT_DONE are dropped
    tx_delay = 20;
    rd_val = 8'h81;
    send(8'h52, 1, 0, n);
    send(8'h44, 1, 0, n);
    q_re.push_back('{n + 1, 8'h44, 8'h00});
    q_tx.push_back('{n + 3, 8'h00, 8'h81});
    repeat (6) @(posedge i_clk);
    send(8'h52, 1, 0, n);
    send(8'h41, 1, 0, n);
    wait_idle(100);
    check("drop_addr_kept", o_reg_addr, 8'h44);
    tx_delay = 3;

    // Asynchronous reset while in SEND
    send(8'h41, 1, 0, n);
    q_err.push_back('{n + 1, 8'h00, 8'h00});
    @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    // Alive after reset
    send(8'h57, 1, 0, n);
    send(8'h01, 1, 0, n);
    send(8'h02, 1, 0, n);
    q_we.push_back('{n + 1, 8'h01, 8'h02});
    q_tx.push_back('{n + 2, 8'h00, 8'h06});
    wait_idle(100);

    check("sb_we_left", q_we.size(), 0);
    check("sb_re_left", q_re.size(), 0);
    check("sb_err_left", q_err.size(), 0);
    check("sb_tx_left", q_tx.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
